// File: rtl/lemming_pkg.sv
// Shared constants for the lemming world environment model.
package lemming_pkg;

    localparam int SPLAT_LIMIT = 20;
    localparam int FALL_CNT_W  = 5;
    localparam int DEPTH_W     = 8;
    localparam int DIG_CNT_W   = 4;

endpackage

// File: rtl/lemming_world_terrain.sv
// Ground bitmap for the corridor: bulk load, reload-to-init, single-cell clear and a read port.
module lemming_world_terrain #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] INIT_GROUND = '1,
    parameter int               POS_W       = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             reload_i,
    input  logic             clr_i,
    input  logic [POS_W-1:0] pos_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] map_q, map_d;

    // An external load wins over everything; a landing reload wins over a dig clear.
    always_comb begin
        map_d = map_q;
        if (load_i) begin
            map_d = load_data_i;
        end else if (reload_i) begin
            map_d = INIT_GROUND;
        end else if (clr_i) begin
            map_d[pos_i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            map_q <= INIT_GROUND;
        end else begin
            map_q <= map_d;
        end
    end

    assign bit_o = map_q[pos_i];

endmodule

// File: rtl/lemming_world.sv
// Closed-loop environment for the lemming walker FSM: position, digging, falling and sensors.
// Optional LEMMING_WORLD_SPLAT_EN enables the sticky splat flag on over-long falls.
module lemming_world
    import lemming_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               START_POS   = WIDTH / 2,
    parameter logic [WIDTH-1:0] INIT_GROUND = '1,
    parameter int               DIG_CYCLES  = 4,
    parameter int               FALL_CYCLES = 3,
    localparam int              POS_W       = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               walk_left,
    input  logic               walk_right,
    input  logic               aaah,
    input  logic               digging,
    input  logic               map_load,
    input  logic [WIDTH-1:0]   map_data,
    output logic               bump_left,
    output logic               bump_right,
    output logic               ground,
    output logic [POS_W-1:0]   pos,
    output logic [DEPTH_W-1:0] depth,
    output logic               splat,
    output logic               protocol_err
);

    localparam logic [POS_W-1:0]      POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]      POS_MAX   = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0]      POS_START = POS_W'(START_POS);
    localparam logic [DIG_CNT_W-1:0]  DIG_LAST  = DIG_CNT_W'(DIG_CYCLES - 1);
    localparam logic [FALL_CNT_W-1:0] FALL_DONE = FALL_CNT_W'(FALL_CYCLES);

    logic [POS_W-1:0]      pos_q, pos_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [DIG_CNT_W-1:0]  dig_cnt_q, dig_cnt_d;
    logic [FALL_CNT_W-1:0] fall_cnt_q, fall_cnt_d;
    logic                  aaah_q;
    logic                  splat_q, splat_d;
    logic                  perr_q, perr_d;
    logic                  violation, landing, dig_done, map_bit;

    assign violation = (walk_left && walk_right)
                    || (aaah && (walk_left || walk_right || digging))
                    || (digging && (walk_left || walk_right));
    assign landing   = aaah_q && !aaah;
    assign dig_done  = digging && (dig_cnt_q == DIG_LAST);

    always_comb begin
        pos_d      = pos_q;
        depth_d    = depth_q;
        dig_cnt_d  = dig_cnt_q;
        fall_cnt_d = fall_cnt_q;
        perr_d     = perr_q | violation;
        splat_d    = 1'b0;

        // Position is frozen mid-fall and while the lemming outputs are inconsistent.
        if (!violation && !aaah) begin
            if (walk_left && pos_q != '0) begin
                pos_d = pos_q - POS_ONE;
            end else if (walk_right && pos_q != POS_MAX) begin
                pos_d = pos_q + POS_ONE;
            end
        end

        if (landing || !digging || dig_done) begin
            dig_cnt_d = '0;
        end else begin
            dig_cnt_d = dig_cnt_q + DIG_CNT_W'(1);
        end

        if (landing) begin
            fall_cnt_d = '0;
        end else if (aaah && fall_cnt_q != '1) begin
            fall_cnt_d = fall_cnt_q + FALL_CNT_W'(1);
        end

        if (landing && depth_q != '1) begin
            depth_d = depth_q + DEPTH_W'(1);
        end

`ifdef LEMMING_WORLD_SPLAT_EN
        splat_d = splat_q | (landing && (fall_cnt_q > FALL_CNT_W'(SPLAT_LIMIT)));
`else
        splat_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pos_q      <= POS_START;
            depth_q    <= '0;
            dig_cnt_q  <= '0;
            fall_cnt_q <= '0;
            aaah_q     <= 1'b0;
            splat_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            depth_q    <= depth_d;
            dig_cnt_q  <= dig_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            aaah_q     <= aaah;
            splat_q    <= splat_d;
            perr_q     <= perr_d;
        end
    end

    lemming_world_terrain #(
        .WIDTH       (WIDTH),
        .INIT_GROUND (INIT_GROUND),
        .POS_W       (POS_W)
    ) u_terrain (
        .clk         (clk),
        .areset_n    (areset_n),
        .load_i      (map_load),
        .load_data_i (map_data),
        .reload_i    (landing),
        .clr_i       (dig_done),
        .pos_i       (pos_q),
        .bit_o       (map_bit)
    );

    assign bump_left    = walk_left && (pos_q == '0);
    assign bump_right   = walk_right && (pos_q == POS_MAX);
    assign ground       = aaah ? (fall_cnt_q >= FALL_DONE) : map_bit;
    assign pos          = pos_q;
    assign depth        = depth_q;
    assign splat        = splat_q;
    assign protocol_err = perr_q;

endmodule
